// File: rtl/pyramid_controller.sv
// pyramid_controller
// Game-level sequencer for the Q*bert pyramid. Holds Q*bert's cube coordinate,
// animates jumps between cube points, tracks which cubes have been visited and
// flags level completion. Optional feature macro: LIVES_EN (adds a lives counter
// and a terminal game-over state).
//
// Ports:
//   clk, reset        system clock, synchronous active-low reset
//   frame_tick        one-cycle pulse per video frame, paces jump/fall animation
//   jump_req/jump_dir held jump request and direction (0=DL 1=DR 2=UL 3=UR)
//   jump_ack          one-cycle pulse when a request is accepted
//   qbert_x/qbert_y   Q*bert screen point for the cube generators
//   qbert_row/col     current cube coordinate (valid while idle)
//   rd_row/rd_col     visited-bit read address; rd_visited one cycle later
//   visited_cnt       number of visited cubes; level_done when all visited
//   falling           high while falling off the pyramid
//   lives             (LIVES_EN only) remaining lives
module pyramid_controller #(
    parameter int ROWS       = 7,
    parameter int X_ORIGIN   = 100,
    parameter int Y_ORIGIN   = 400,
    parameter int XSTEP      = 60,
    parameter int YDIAG_DEMI = 40,
    parameter int JUMP_LOG2  = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        jump_req,
    input  logic [1:0]  jump_dir,
    output logic        jump_ack,
    output logic [10:0] qbert_x,
    output logic [9:0]  qbert_y,
    output logic [2:0]  qbert_row,
    output logic [2:0]  qbert_col,
    input  logic [2:0]  rd_row,
    input  logic [2:0]  rd_col,
    output logic        rd_visited,
    output logic [5:0]  visited_cnt,
    output logic        level_done,
    output logic        falling
`ifdef LIVES_EN
    ,
    output logic [1:0]  lives
`endif
);

    localparam int N         = ROWS * (ROWS + 1) / 2;
    localparam int IW        = $clog2(N);
    localparam int FALL_STEP = XSTEP >> 1;

    typedef enum logic [2:0] {
        StIdle, StJump, StLand, StFall, StRespawn, StGameover
    } state_e;

    state_e                 state_q, state_d;
    logic [2:0]             row_q, row_d, col_q, col_d;
    logic [2:0]             tr_q, tr_d, tc_q, tc_d;
    logic [JUMP_LOG2-1:0]   k_q, k_d, kn;
    logic [10:0]            sx_q, sx_d, qx_q, qx_d;
    logic [9:0]             sy_q, sy_d, qy_q, qy_d;
    logic [N-1:0]           visited_q, visited_d;
    logic [5:0]             cnt_q, cnt_d;
    logic                   ack_q, ack_d;
    logic                   rdv_q, rdv_d;
    logic [IW-1:0]          land_idx;
    int                     ntr, ntc, ix, iy, fx;
`ifdef LIVES_EN
    logic [1:0]             lives_q, lives_d;
`endif

    function automatic logic [10:0] pos_x(input logic [2:0] r);
        int v;
        v = X_ORIGIN + int'(r) * XSTEP;
        return v[10:0];
    endfunction

    function automatic logic [9:0] pos_y(input logic [2:0] r, input logic [2:0] c);
        int v;
        v = Y_ORIGIN - int'(r) * YDIAG_DEMI + 2 * int'(c) * YDIAG_DEMI;
        return v[9:0];
    endfunction

    // Row-major triangular index: row r starts at r*(r+1)/2.
    function automatic logic [IW-1:0] cube_idx(input logic [2:0] r, input logic [2:0] c);
        int v;
        v = int'(r) * (int'(r) + 1) / 2 + int'(c);
        return v[IW-1:0];
    endfunction

    assign land_idx = cube_idx(tr_q, tc_q);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            row_q     <= 3'd0;
            col_q     <= 3'd0;
            tr_q      <= 3'd0;
            tc_q      <= 3'd0;
            k_q       <= '0;
            sx_q      <= pos_x(3'd0);
            sy_q      <= pos_y(3'd0, 3'd0);
            qx_q      <= pos_x(3'd0);
            qy_q      <= pos_y(3'd0, 3'd0);
            visited_q <= N'(1);
            cnt_q     <= 6'd1;
            ack_q     <= 1'b0;
            rdv_q     <= 1'b0;
`ifdef LIVES_EN
            lives_q   <= 2'd3;
`endif
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            tr_q      <= tr_d;
            tc_q      <= tc_d;
            k_q       <= k_d;
            sx_q      <= sx_d;
            sy_q      <= sy_d;
            qx_q      <= qx_d;
            qy_q      <= qy_d;
            visited_q <= visited_d;
            cnt_q     <= cnt_d;
            ack_q     <= ack_d;
            rdv_q     <= rdv_d;
`ifdef LIVES_EN
            lives_q   <= lives_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        tr_d      = tr_q;
        tc_d      = tc_q;
        k_d       = k_q;
        sx_d      = sx_q;
        sy_d      = sy_q;
        qx_d      = qx_q;
        qy_d      = qy_q;
        visited_d = visited_q;
        cnt_d     = cnt_q;
        ack_d     = 1'b0;
        rdv_d     = 1'b0;
`ifdef LIVES_EN
        lives_d   = lives_q;
`endif
        kn  = k_q + JUMP_LOG2'(1);
        ntr = int'(row_q);
        ntc = int'(col_q);
        ix  = 0;
        iy  = 0;
        fx  = int'(qx_q) + FALL_STEP;

        if (int'(rd_row) < ROWS && rd_col <= rd_row) begin
            rdv_d = visited_q[cube_idx(rd_row, rd_col)];
        end

        case (jump_dir)
            2'd0:    begin ntr = int'(row_q) + 1; ntc = int'(col_q);     end
            2'd1:    begin ntr = int'(row_q) + 1; ntc = int'(col_q) + 1; end
            2'd2:    begin ntr = int'(row_q) - 1; ntc = int'(col_q) - 1; end
            default: begin ntr = int'(row_q) - 1; ntc = int'(col_q);     end
        endcase

        case (state_q)
            StIdle: begin
                if (jump_req && !level_done) begin
                    ack_d = 1'b1;
                    sx_d  = qx_q;
                    sy_d  = qy_q;
                    k_d   = '0;
                    if (ntc >= 0 && ntc <= ntr && ntr < ROWS) begin
                        tr_d    = ntr[2:0];
                        tc_d    = ntc[2:0];
                        state_d = StJump;
                    end else begin
                        state_d = StFall;
                    end
                end
            end
            StJump: begin
                if (frame_tick) begin
                    if (k_q == JUMP_LOG2'(2 ** JUMP_LOG2 - 1)) begin
                        qx_d    = pos_x(tr_q);
                        qy_d    = pos_y(tr_q, tc_q);
                        state_d = StLand;
                    end else begin
                        // Linear interpolation; arithmetic shift keeps upward moves signed.
                        ix   = int'(sx_q) +
                               (((int'(pos_x(tr_q)) - int'(sx_q)) * int'(kn)) >>> JUMP_LOG2);
                        iy   = int'(sy_q) +
                               (((int'(pos_y(tr_q, tc_q)) - int'(sy_q)) * int'(kn)) >>> JUMP_LOG2);
                        qx_d = ix[10:0];
                        qy_d = iy[9:0];
                        k_d  = kn;
                    end
                end
            end
            StLand: begin
                row_d = tr_q;
                col_d = tc_q;
                if (!visited_q[land_idx]) begin
                    visited_d[land_idx] = 1'b1;
                    cnt_d               = cnt_q + 6'd1;
                end
                state_d = StIdle;
            end
            StFall: begin
                if (frame_tick) begin
                    qx_d = (fx > 2047) ? 11'd2047 : fx[10:0];
                    if (k_q == JUMP_LOG2'(2 ** JUMP_LOG2 - 1)) begin
                        state_d = StRespawn;
                    end else begin
                        k_d = kn;
                    end
                end
            end
            StRespawn: begin
`ifdef LIVES_EN
                if (lives_q <= 2'd1) begin
                    lives_d = 2'd0;
                    state_d = StGameover;
                end else begin
                    lives_d = lives_q - 2'd1;
                    row_d   = 3'd0;
                    col_d   = 3'd0;
                    qx_d    = pos_x(3'd0);
                    qy_d    = pos_y(3'd0, 3'd0);
                    state_d = StIdle;
                end
`else
                row_d   = 3'd0;
                col_d   = 3'd0;
                qx_d    = pos_x(3'd0);
                qy_d    = pos_y(3'd0, 3'd0);
                state_d = StIdle;
`endif
            end
            StGameover: begin
                state_d = StGameover;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign jump_ack    = ack_q;
    assign qbert_x     = qx_q;
    assign qbert_y     = qy_q;
    assign qbert_row   = row_q;
    assign qbert_col   = col_q;
    assign rd_visited  = rdv_q;
    assign visited_cnt = cnt_q;
    assign level_done  = (cnt_q == 6'(N));
    assign falling     = (state_q == StFall);
`ifdef LIVES_EN
    assign lives       = lives_q;
`endif

endmodule
